// File: rtl/pll_reset_sequencer.sv
// Power-up and lock supervisor for an iCE40 PLL: sequences PLL RESETB, waits for a
// stable synchronized lock, then releases the core reset; retries and faults on lock failure.
module pll_reset_sequencer #(
  parameter int PLL_RESET_CYCLES   = 16,
  parameter int LOCK_TIMEOUT       = 4096,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CORE_RESET_CYCLES  = 16,
  parameter int MAX_RETRIES        = 3,
  parameter int CNT_W              = 16,
  parameter int RETRY_W            = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               soft_reset_req,
  output logic               pll_resetb,
  output logic               core_reset,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count
);

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    CORE_RST,
    RUN,
    FAULT
  } state_t;

  localparam logic [CNT_W-1:0]   PLL_RST_LAST   = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CORE_RST_LAST  = CNT_W'(CORE_RESET_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT    = RETRY_W'(MAX_RETRIES);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic [1:0]         sync_reg;
  logic               lock_s;

  logic pll_resetb_reg, pll_resetb_next;
  logic core_reset_reg, core_reset_next;
  logic ready_reg, ready_next;
  logic fault_reg, fault_next;

  // LOCK is asynchronous to clk; only the second flop's output is used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], pll_locked};
    end
  end

  assign lock_s = sync_reg[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= PLL_RST;
      cnt_reg        <= '0;
      retry_reg      <= '0;
      pll_resetb_reg <= 1'b0;
      core_reset_reg <= 1'b1;
      ready_reg      <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      retry_reg      <= retry_next;
      pll_resetb_reg <= pll_resetb_next;
      core_reset_reg <= core_reset_next;
      ready_reg      <= ready_next;
      fault_reg      <= fault_next;
    end
  end

  // Lock loss is tested first in every locked state so it wins over expiry and soft reset.
  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    case (state_reg)
      PLL_RST: begin
        if (cnt_reg == PLL_RST_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = STABLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          if (retry_reg == RETRY_LIMIT) begin
            state_next = FAULT;
          end else begin
            retry_next = retry_reg + RETRY_W'(1);
            state_next = PLL_RST;
          end
        end
      end
      STABLE: begin
        if (!lock_s)                     state_next = WAIT_LOCK;
        else if (cnt_reg == STABLE_LAST) state_next = CORE_RST;
      end
      CORE_RST: begin
        if (!lock_s)                       state_next = WAIT_LOCK;
        else if (cnt_reg == CORE_RST_LAST) state_next = RUN;
      end
      RUN: begin
        if (!lock_s)             state_next = WAIT_LOCK;
        else if (soft_reset_req) state_next = CORE_RST;
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = PLL_RST;
      end
    endcase

    cnt_next = (state_next != state_reg) ? '0 : cnt_reg + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pll_resetb_next = 1'b1;
    core_reset_next = 1'b1;
    ready_next      = 1'b0;
    fault_next      = 1'b0;
    case (state_next)
      PLL_RST: begin
        pll_resetb_next = 1'b0;
      end
      RUN: begin
        core_reset_next = 1'b0;
        ready_next      = 1'b1;
      end
      FAULT: begin
        pll_resetb_next = 1'b0;
        fault_next      = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pll_resetb  = pll_resetb_reg;
  assign core_reset  = core_reset_reg;
  assign ready       = ready_reg;
  assign fault       = fault_reg;
  assign retry_count = retry_reg;

endmodule
